tx_frame_sched: RTL and testbench
=================================

// Module: tx_frame_sched
// PURPOSE
//  Frame scheduler between the CP-insertion stage and the preamble/output stage of the OFDM Tx.
//  Cuts the continuous symbol stream into frames of NSYM_I symbols.
//  Opens a bus cycle (CYC_O) per frame, so the downstream stage inserts its preamble once per frame.
//  Closes the cycle after exactly NSYM_I*SYM_LEN samples, then enforces a configurable inter-frame gap.
// PARAMETERS
//  SYM_LEN  80  samples per OFDM symbol (64 FFT + 16 CP)
//  NSYM_W   8   width of symbols-per-frame config
//  GAP_W    16  width of inter-frame gap config
//  MIN_GAP  4   minimum gap in cycles; GAP_I below this is raised to MIN_GAP
// PORTS
//  CLK_I       in   1       clock
//  RST_I       in   1       synchronous reset, active-high
//  DAT_I       in   32      upstream sample {I[15:0],Q[15:0]}
//  CYC_I       in   1       upstream cycle
//  STB_I       in   1       upstream strobe
//  WE_I        in   1       upstream write enable
//  ACK_O       out  1       upstream acknowledge
//  DAT_O       out  32      sample to output stage
//  CYC_O       out  1       frame cycle to output stage
//  STB_O       out  1       strobe to output stage
//  WE_O        out  1       = STB_O
//  ACK_I       in   1       acknowledge from output stage
//  EN_I        in   1       scheduler enable; low blocks new frames only
//  NSYM_I      in   NSYM_W  symbols per frame; sampled at frame start; 0 treated as 1
//  GAP_I       in   GAP_W   idle cycles between frames; sampled at frame start
//  BUSY_O      out  1       high in any state other than IDLE
//  FRM_DONE_O  out  1       1-cycle pulse on FRAME->GAP
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; counters 0.
//  Reset mid-frame: CYC_O and STB_O drop the next cycle; the buffered sample is discarded.
//  Definitions:
//   ena = CYC_I & STB_I & WE_I
//   LIMIT = max(NSYM,1)*SYM_LEN, held in a counter of width NSYM_W+$clog2(SYM_LEN)
//  States:
//   IDLE: if EN_I & ena -> FRAME. Latch NSYM_I and GAP_I, set CYC_O=1, clear iss_cnt and done_cnt.
//   FRAME: ACK_O = ena & (~STB_O | ACK_I) & (iss_cnt != LIMIT); combinational.
//     On ACK_O: DAT_O<=DAT_I, STB_O<=1, iss_cnt++.
//     On STB_O&ACK_I with no new ACK_O: STB_O<=0.
//     On STB_O&ACK_I: done_cnt++.
//     Last ACK_I (done_cnt==LIMIT-1): STB_O<=0, CYC_O<=0, FRM_DONE_O pulse, -> GAP.
//   GAP: CYC_O=0, STB_O=0, ACK_O=0; count gap_cnt up to latched gap-1 -> IDLE.
//  Handshake:
//   DAT_O/STB_O are held stable while STB_O & ~ACK_I.
//   ACK_I is honoured only while STB_O is high.
//   Latency upstream accept -> STB_O is 1 cycle.
//   Throughput is 1 sample/cycle while ACK_I stays high.
//  Upstream underrun in FRAME (ena low):
//   STB_O drops after the pending ACK; CYC_O stays high.
//   The frame resumes when ena returns. Frame length is never altered.
//  EN_I low mid-frame: the current frame completes; no new frame starts.
//  NSYM_I and GAP_I changes mid-frame take effect only at the next frame start.
//  Simultaneous ACK_I on the last sample with ena high: the sample is not accepted (iss_cnt==LIMIT).
// CONFIGURATION
//  TX_SCHED_ABORT_EN defined:
//   Adds input port ABORT_I (1 bit). It is sampled in FRAME only and sets a sticky abort_req.
//   LIMIT is then truncated to the next symbol boundary: ceil(iss_cnt/SYM_LEN)*SYM_LEN.
//   If iss_cnt is already on a boundary, that value is used unchanged.
//   The frame closes through GAP as normal; abort_req clears in GAP.
//  TX_SCHED_ABORT_EN not defined: no ABORT_I port; frames always run to full LIMIT.
// TESTING
//  T1 NSYM_I=2, GAP_I=10, ACK_I always high, continuous upstream
//     -> exactly 160 STB_O&ACK_I beats; CYC_O falls the cycle after beat 160; FRM_DONE_O=1 once.
//  T2 Back-to-back frames, GAP_I=10
//     -> CYC_O low for exactly 10 cycles between frames.
//     GAP_I=1 -> CYC_O low for 4 cycles (MIN_GAP).
//  T3 ACK_I low for 320 cycles after CYC_O rises (preamble), then random stalls 30%
//     -> DAT_O stable across every stall; sample order preserved; 80*NSYM samples per frame.
//  T4 NSYM_I=0 -> 80-sample frame.
//     NSYM_I changed 1->3 mid-frame -> current frame 80 samples, next frame 240.
//  T5 STB_I low for 20 cycles mid-frame -> CYC_O held high, STB_O low, total count unchanged.
//     RST_I pulse at sample 50 -> next cycle all outputs 0, BUSY_O=0.
//  T6 (TX_SCHED_ABORT_EN) NSYM_I=4, ABORT_I at iss_cnt=100 -> frame ends after 160 samples.
//     ABORT_I at iss_cnt=160 -> frame ends after 160 samples.

Source files
------------

// File: rtl/tx_frame_sched.sv
// Frame scheduler between the CP-insertion stage and the preamble/output stage of the OFDM Tx.
// Optional frame abort (ABORT_I) is enabled by defining TX_SCHED_ABORT_EN.
module tx_frame_sched #(
  parameter int unsigned SYM_LEN = 80,
  parameter int unsigned NSYM_W  = 8,
  parameter int unsigned GAP_W   = 16,
  parameter int unsigned MIN_GAP = 4
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [31:0]       DAT_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  output logic              ACK_O,
  output logic [31:0]       DAT_O,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  input  logic              ACK_I,
  input  logic              EN_I,
  input  logic [NSYM_W-1:0] NSYM_I,
  input  logic [GAP_W-1:0]  GAP_I,
`ifdef TX_SCHED_ABORT_EN
  input  logic              ABORT_I,
`endif
  output logic              BUSY_O,
  output logic              FRM_DONE_O
);

  localparam int unsigned SW = $clog2(SYM_LEN);
  localparam int unsigned CW = NSYM_W + SW;

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP} state_t;

  state_t          state;
  logic [CW-1:0]   limit_q;
  logic [CW-1:0]   eff_limit;
  logic [CW-1:0]   iss_cnt;
  logic [CW-1:0]   done_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic            ena;
  logic            beat;
  logic            last_beat;

  assign ena       = CYC_I & STB_I & WE_I;
  assign beat      = STB_O & ACK_I;
  assign last_beat = beat && (done_cnt == eff_limit - CW'(1));
  assign WE_O      = STB_O;
  assign ACK_O     = (state == S_FRAME) & ena & (~STB_O | ACK_I) & (iss_cnt != eff_limit);

`ifdef TX_SCHED_ABORT_EN
  logic          abort_req;
  logic [SW-1:0] sym_pos;
  logic [CW-1:0] trunc_limit;

  // Round the issued count up to the next symbol boundary; an empty frame still gets one symbol.
  always_comb begin
    trunc_limit = limit_q;
    if (sym_pos == '0 && iss_cnt != '0)
      trunc_limit = iss_cnt;
    else
      trunc_limit = iss_cnt - CW'(sym_pos) + CW'(SYM_LEN);
  end

  assign eff_limit = ((state == S_FRAME) && (abort_req || ABORT_I)) ? trunc_limit : limit_q;

  // Sticky abort request and position of iss_cnt within the current symbol.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      abort_req <= 1'b0;
      sym_pos   <= '0;
    end else begin
      case (state)
        S_IDLE: sym_pos <= '0;
        S_FRAME: begin
          if (ABORT_I) abort_req <= 1'b1;
          if (ACK_O) sym_pos <= (sym_pos == SW'(SYM_LEN - 1)) ? '0 : sym_pos + SW'(1);
        end
        default: abort_req <= 1'b0;
      endcase
    end
  end
`else
  assign eff_limit = limit_q;
`endif

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state      <= S_IDLE;
      limit_q    <= '0;
      iss_cnt    <= '0;
      done_cnt   <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      DAT_O      <= '0;
      CYC_O      <= 1'b0;
      STB_O      <= 1'b0;
      BUSY_O     <= 1'b0;
      FRM_DONE_O <= 1'b0;
    end else begin
      FRM_DONE_O <= 1'b0;
      case (state)
        S_IDLE: begin
          if (EN_I && ena) begin
            state    <= S_FRAME;
            BUSY_O   <= 1'b1;
            CYC_O    <= 1'b1;
            iss_cnt  <= '0;
            done_cnt <= '0;
            limit_q  <= ((NSYM_I == '0) ? CW'(1) : CW'(NSYM_I)) * CW'(SYM_LEN);
            gap_q    <= (GAP_I < GAP_W'(MIN_GAP)) ? GAP_W'(MIN_GAP) : GAP_I;
          end
        end

        S_FRAME: begin
          if (last_beat) begin
            state      <= S_GAP;
            STB_O      <= 1'b0;
            CYC_O      <= 1'b0;
            FRM_DONE_O <= 1'b1;
            // The IDLE cycle before the next CYC_O rise is the final gap cycle.
            gap_cnt    <= GAP_W'(1);
          end else begin
            if (ACK_O) begin
              DAT_O   <= DAT_I;
              STB_O   <= 1'b1;
              iss_cnt <= iss_cnt + CW'(1);
            end else if (beat) begin
              STB_O <= 1'b0;
            end
            if (beat) done_cnt <= done_cnt + CW'(1);
          end
        end

        S_GAP: begin
          if (gap_cnt == gap_q - GAP_W'(1)) begin
            state  <= S_IDLE;
            BUSY_O <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed self-checking bench for tx_frame_sched: frame length, gap, stalls, underrun, reset.
module tb_tx_frame_sched;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [31:0] DAT_I;
  logic        CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O, STB_O, WE_O;
  logic        ACK_I = 1'b0;
  logic        EN_I = 1'b0;
  logic [7:0]  NSYM_I = 8'd1;
  logic [15:0] GAP_I = 16'd10;
  logic        BUSY_O, FRM_DONE_O;
`ifdef TX_SCHED_ABORT_EN
  logic        ABORT_I = 1'b0;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  tx_frame_sched dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I),
    .EN_I(EN_I), .NSYM_I(NSYM_I), .GAP_I(GAP_I),
`ifdef TX_SCHED_ABORT_EN
    .ABORT_I(ABORT_I),
`endif
    .BUSY_O(BUSY_O), .FRM_DONE_O(FRM_DONE_O)
  );

  always #5 CLK_I = ~CLK_I;

  // Upstream source: an incrementing sample stream advanced on each accept.
  logic [31:0] src_seq = 32'd1000;
  assign DAT_I = src_seq;
  always @(posedge CLK_I) if (!RST_I && ACK_O) src_seq <= src_seq + 32'd1;

  // Bus monitor: frame lengths, gaps, pulses, ordering and stall stability.
  logic        mon_beat;
  assign mon_beat = STB_O & ACK_I;
  int          rises = 0, frames_done = 0, done_pulses = 0;
  int          cur_beats = 0, acc_cnt = 0, last_frame = 0, low_cnt = 0, last_gap = 0;
  int          order_err = 0, stab_err = 0;
  logic        fall_after_beat = 1'b0, have_last = 1'b0;
  logic        cyc_d = 1'b0, beat_d = 1'b0, stb_d = 1'b0, ack_d = 1'b0;
  logic [31:0] dat_d = '0, last_dat = '0;

  always @(posedge CLK_I) begin
    if (RST_I) begin
      have_last <= 1'b0; cur_beats <= 0; acc_cnt <= 0; low_cnt <= 0;
      cyc_d <= 1'b0; beat_d <= 1'b0; stb_d <= 1'b0; ack_d <= 1'b0;
    end else begin
      if (stb_d && !ack_d && (!STB_O || DAT_O != dat_d)) stab_err <= stab_err + 1;
      if (mon_beat) begin
        if (have_last && DAT_O != last_dat + 32'd1) order_err <= order_err + 1;
        last_dat  <= DAT_O;
        have_last <= 1'b1;
      end
      if (!cyc_d && CYC_O) begin
        rises <= rises + 1; last_gap <= low_cnt; low_cnt <= 0; cur_beats <= 0; acc_cnt <= 0;
      end else begin
        if (!CYC_O) low_cnt <= low_cnt + 1;
        if (CYC_O && mon_beat) cur_beats <= cur_beats + 1;
        if (ACK_O) acc_cnt <= acc_cnt + 1;
      end
      if (cyc_d && !CYC_O) begin
        frames_done <= frames_done + 1; last_frame <= cur_beats; fall_after_beat <= beat_d;
      end
      if (FRM_DONE_O) done_pulses <= done_pulses + 1;
      cyc_d <= CYC_O; beat_d <= mon_beat; stb_d <= STB_O; ack_d <= ACK_I; dat_d <= DAT_O;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_rises(input int target, input int budget);
    int n = 0;
    while (rises < target && n < budget) begin @(negedge CLK_I); n++; end
    check("rise_timeout", 32'(rises >= target), 32'd1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin @(negedge CLK_I); n++; end
    check("frame_timeout", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (BUSY_O && n < budget) begin @(negedge CLK_I); n++; end
    check("idle_timeout", 32'(BUSY_O), 32'd0);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (cur_beats < target && n < budget) begin @(negedge CLK_I); n++; end
    check("beat_timeout", 32'(cur_beats >= target), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cyc"}, 32'(CYC_O), 32'd0);
    check({tag, "_stb"}, 32'(STB_O), 32'd0);
    check({tag, "_we"}, 32'(WE_O), 32'd0);
    check({tag, "_ack"}, 32'(ACK_O), 32'd0);
    check({tag, "_busy"}, 32'(BUSY_O), 32'd0);
    check({tag, "_done"}, 32'(FRM_DONE_O), 32'd0);
    check({tag, "_dat"}, DAT_O, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge CLK_I);
    check_outputs_zero("reset");
    RST_I = 1'b0;

    // T1: 2-symbol frame, continuous upstream, ACK always high
    NSYM_I = 8'd2; GAP_I = 16'd10; ACK_I = 1'b1;
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; EN_I = 1'b1;
    wait_rises(2, 2000);
    check("t1_len", 32'(last_frame), 32'd160);
    check("t1_fall_after_last", 32'(fall_after_beat), 32'd1);
    check("t1_done_pulses", 32'(done_pulses), 32'd1);
    // T2: gap length; GAP_I change takes effect at the next frame start
    check("t2_gap10", 32'(last_gap), 32'd10);
    GAP_I = 16'd1;
    wait_rises(3, 2000);
    check("t2_gap_latched", 32'(last_gap), 32'd10);
    wait_rises(4, 2000);
    check("t2_min_gap", 32'(last_gap), 32'd4);
    EN_I = 1'b0;
    wait_idle(2000);
    check("t2_frames", 32'(frames_done), 32'd4);
    check("t2_len", 32'(last_frame), 32'd160);

    // T3: long preamble stall then random stalls
    NSYM_I = 8'd1; GAP_I = 16'd10; ACK_I = 1'b0; EN_I = 1'b1;
    wait_rises(5, 2000);
    EN_I = 1'b0;
    repeat (320) @(negedge CLK_I);
    check("t3_hold_stb", 32'(STB_O), 32'd1);
    begin
      int n = 0;
      while (frames_done < 5 && n < 3000) begin
        @(negedge CLK_I);
        ACK_I = ($urandom_range(0, 99) >= 30);
        n++;
      end
    end
    ACK_I = 1'b1;
    check("t3_done", 32'(frames_done), 32'd5);
    check("t3_len", 32'(last_frame), 32'd80);
    check("t3_stable", 32'(stab_err), 32'd0);
    check("t3_order", 32'(order_err), 32'd0);
    wait_idle(2000);

    // T4: NSYM_I=0 means one symbol; NSYM_I change mid-frame
    NSYM_I = 8'd0; EN_I = 1'b1;
    wait_rises(6, 2000);
    EN_I = 1'b0;
    wait_frames(6, 2000);
    check("t4_nsym0", 32'(last_frame), 32'd80);
    wait_idle(2000);
    NSYM_I = 8'd1; EN_I = 1'b1;
    wait_rises(7, 2000);
    NSYM_I = 8'd3;
    wait_rises(8, 2000);
    EN_I = 1'b0;
    check("t4_before_change", 32'(last_frame), 32'd80);
    wait_frames(8, 2000);
    check("t4_after_change", 32'(last_frame), 32'd240);
    wait_idle(2000);

    // T5: upstream underrun mid-frame
    NSYM_I = 8'd2; EN_I = 1'b1;
    wait_rises(9, 2000);
    EN_I = 1'b0;
    wait_beats(50, 2000);
    STB_I = 1'b0;
    repeat (5) @(negedge CLK_I);
    check("t5_cyc_held", 32'(CYC_O), 32'd1);
    check("t5_stb_low", 32'(STB_O), 32'd0);
    check("t5_ack_low", 32'(ACK_O), 32'd0);
    repeat (15) @(negedge CLK_I);
    STB_I = 1'b1;
    wait_frames(9, 2000);
    check("t5_len", 32'(last_frame), 32'd160);
    check("t5_order", 32'(order_err), 32'd0);
    wait_idle(2000);

    // T5: reset mid-frame, then recovery
    EN_I = 1'b1;
    wait_rises(10, 2000);
    EN_I = 1'b0;
    wait_beats(50, 2000);
    RST_I = 1'b1;
    @(negedge CLK_I);
    check_outputs_zero("midrst");
    RST_I = 1'b0;
    NSYM_I = 8'd1; EN_I = 1'b1;
    wait_rises(11, 2000);
    EN_I = 1'b0;
    wait_frames(10, 2000);
    check("recover_len", 32'(last_frame), 32'd80);
    check("final_order", 32'(order_err), 32'd0);
    check("final_stable", 32'(stab_err), 32'd0);
    wait_idle(2000);

`ifdef TX_SCHED_ABORT_EN
    // T6: abort truncates to the next symbol boundary
    NSYM_I = 8'd4; EN_I = 1'b1;
    wait_rises(12, 2000);
    EN_I = 1'b0;
    begin
      int n = 0;
      while (acc_cnt < 100 && n < 2000) begin @(negedge CLK_I); n++; end
    end
    ABORT_I = 1'b1; @(negedge CLK_I); ABORT_I = 1'b0;
    wait_frames(11, 2000);
    check("t6_abort100", 32'(last_frame), 32'd160);
    wait_idle(2000);
    EN_I = 1'b1;
    wait_rises(13, 2000);
    EN_I = 1'b0;
    begin
      int n = 0;
      while (acc_cnt < 160 && n < 2000) begin @(negedge CLK_I); n++; end
    end
    ABORT_I = 1'b1; @(negedge CLK_I); ABORT_I = 1'b0;
    wait_frames(12, 2000);
    check("t6_abort160", 32'(last_frame), 32'd160);
    wait_idle(2000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
